// File: rtl/sram_controller_if.sv
// Requester-side bundle between the cache controller and the SRAM controller.
// The cache controller drives the request and samples ready/data_out.
interface sram_controller_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data;
  logic [17:0] address;
  logic        ready;
  logic [63:0] data_out;

  modport master (
    output mem_read, mem_write, data, address,
    input  ready, data_out
  );

  modport slave (
    input  mem_read, mem_write, data, address,
    output ready, data_out
  );
endinterface

// File: rtl/sram_controller.sv
// Sequences single-word writes (two halfword strobes) and 4-halfword block
// reads onto a 16-bit asynchronous SRAM. Every access occupies LATENCY BUSY
// cycles followed by a one-cycle DONE; the requester is stalled through ready.
module sram_controller #(
  parameter int LATENCY = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  sram_controller_if.slave        bus,
  inout  wire  [15:0]             SRAM_DQ,
  output logic [17:0]             SRAM_ADDR,
  output logic                    SRAM_WE_N
);

  localparam int CNT_W = ($clog2(LATENCY) < 3) ? 3 : $clog2(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op_write;
  logic [17:0]        r_addr;
  logic [31:0]        r_data;
  logic [15:0]        r_hw [0:3];
  logic [17:0]        r_addr_hold;
  logic [63:0]        r_data_out;

  logic               w_req;
  logic               w_last;
  logic               w_ready;
  logic               w_we_n;
  logic               w_dq_oe;
  logic [15:0]        w_dq_out;
  logic [17:0]        w_sram_addr;
  logic [15:0]        w_hw3;

  assign w_req  = bus.mem_read | bus.mem_write;
  assign w_last = (r_cnt == CNT_W'(LATENCY - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode: an access always runs LATENCY BUSY cycles then DONE.
  always_comb begin
    // NOTE: default first so no path leaves w_state_next unassigned (no latch).
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req)  w_state_next = ST_BUSY;
      ST_BUSY: if (w_last) w_state_next = ST_DONE;
      ST_DONE:             w_state_next = ST_IDLE;
      default:             w_state_next = ST_IDLE;
    endcase
  end

  // Output decode: SRAM pins depend only on state, cnt and latched request.
  always_comb begin
    w_ready     = 1'b0;
    w_we_n      = 1'b1;
    w_dq_oe     = 1'b0;
    w_dq_out    = r_data[15:0];
    w_sram_addr = r_addr_hold;
    case (r_state)
      ST_IDLE: w_ready = ~w_req;
      ST_DONE: w_ready = 1'b1;
      ST_BUSY: begin
        if (r_op_write) begin
          if (r_cnt < CNT_W'(2)) begin
            w_we_n      = 1'b0;
            w_dq_oe     = 1'b1;
            w_dq_out    = r_cnt[0] ? r_data[31:16] : r_data[15:0];
            w_sram_addr = {r_addr[17:1], r_cnt[0]};
          end
        end else if (r_cnt < CNT_W'(4)) begin
          w_sram_addr = {r_addr[17:2], r_cnt[1:0]};
        end
      end
      default: w_ready = 1'b0;
    endcase
  end

  // Control datapath: cycle counter, held address and the read result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_addr_hold <= '0;
      r_data_out  <= '0;
    end else begin
      r_addr_hold <= w_sram_addr;
      case (r_state)
        ST_IDLE: if (w_req) r_cnt <= '0;
        ST_BUSY: begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last && !r_op_write)
            r_data_out <= {w_hw3, r_hw[2], r_hw[1], r_hw[0]};
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // With LATENCY==4 the last halfword arrives on the completion edge itself.
  assign w_hw3 = (r_cnt == CNT_W'(3)) ? SRAM_DQ : r_hw[3];

  // Request latch and halfword capture buffer.
  always_ff @(posedge clk) begin
    // NOTE: pure data registers carry no reset; they are only consumed after
    // the FSM has loaded them, so a reset term would add nothing.
    if (r_state == ST_IDLE && w_req) begin
      r_op_write <= bus.mem_write;
      r_addr     <= bus.address;
      r_data     <= bus.data;
    end
    if (r_state == ST_BUSY && !r_op_write && r_cnt < CNT_W'(4))
      r_hw[r_cnt[1:0]] <= SRAM_DQ;
  end

  assign SRAM_DQ      = w_dq_oe ? w_dq_out : 16'hzzzz;
  assign SRAM_ADDR    = w_sram_addr;
  assign SRAM_WE_N    = w_we_n;
  assign bus.ready    = w_ready;
  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with an asynchronous SRAM model and
// a read-result scoreboard.
module tb_sram_controller;

  localparam int LAT = 6;

  logic        clk;
  logic        rst;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        model_oe;
  logic [15:0] mem [0:255];
  logic [63:0] exp_q [$];
  logic [63:0] exp_data_out;
  int          checks;
  int          errors;

  sram_controller_if bus ();

  sram_controller #(.LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .SRAM_DQ  (SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N)
  );

  // Asynchronous SRAM read port: data follows the address within the cycle.
  assign SRAM_DQ = (model_oe && SRAM_WE_N) ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // One request through to DONE, checking ready, pins and data_out per cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [17:0] a,
                           input logic [31:0] d, input bit perturb, input string name);
    logic [17:0] ea;
    logic        ewe;
    logic [15:0] edq;
    logic [7:0]  b;
    logic [63:0] got_exp;
    bit          chk_addr, chk_dq, chk_z;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.mem_read = rd; bus.mem_write = wr; bus.address = a; bus.data = d;
        model_oe = rd && !wr;
        if (rd && !wr) begin
          b = {a[7:2], 2'b00};
          exp_q.push_back({mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]});
        end
      end
      if (k == 2 && perturb) begin
        bus.address = ~a; bus.data = ~d;
      end
      #1;
      checks++;
      if (bus.ready !== (k == LAT + 1)) begin
        errors++; $display("FAIL %s ready k=%0d: got %b want %b", name, k, bus.ready, (k == LAT + 1));
      end
      ewe = 1'b1; edq = 16'h0; ea = '0; chk_addr = 0; chk_dq = 0; chk_z = 0;
      if (wr) begin
        if (k == 0) chk_z = 1;
        else if (k == 1) begin chk_addr = 1; ea = {a[17:1], 1'b0}; ewe = 0; chk_dq = 1; edq = d[15:0]; end
        else if (k == 2) begin chk_addr = 1; ea = {a[17:1], 1'b1}; ewe = 0; chk_dq = 1; edq = d[31:16]; end
        else begin chk_addr = 1; ea = {a[17:1], 1'b1}; chk_z = 1; end
      end else begin
        if (k >= 1 && k <= 4) begin chk_addr = 1; ea = {a[17:2], 2'(k - 1)}; end
        else if (k >= 5) begin chk_addr = 1; ea = {a[17:2], 2'b11}; end
      end
      checks++;
      if (SRAM_WE_N !== ewe) begin
        errors++; $display("FAIL %s we_n k=%0d: got %b want %b", name, k, SRAM_WE_N, ewe);
      end
      if (chk_addr) begin
        checks++;
        if (SRAM_ADDR !== ea) begin
          errors++; $display("FAIL %s addr k=%0d: got %h want %h", name, k, SRAM_ADDR, ea);
        end
      end
      if (chk_dq) begin
        checks++;
        if (SRAM_DQ !== edq) begin
          errors++; $display("FAIL %s dq k=%0d: got %h want %h", name, k, SRAM_DQ, edq);
        end
      end
      if (chk_z) begin
        checks++;
        if (SRAM_DQ !== 16'hzzzz && SRAM_DQ !== 16'h0000) begin
          errors++; $display("FAIL %s dq_release k=%0d: got %h want released", name, k, SRAM_DQ);
        end
      end
      if (!wr && k == LAT + 1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s scoreboard: got empty queue want entry", name);
        end else begin
          got_exp = exp_q.pop_front();
          if (bus.data_out !== got_exp) begin
            errors++; $display("FAIL %s data_out: got %h want %h", name, bus.data_out, got_exp);
          end
          exp_data_out = got_exp;
        end
      end else begin
        checks++;
        if (bus.data_out !== exp_data_out) begin
          errors++; $display("FAIL %s data_out_hold k=%0d: got %h want %h", name, k, bus.data_out, exp_data_out);
        end
      end
      if (k == LAT + 1) begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; model_oe = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.address = '0; bus.data = '0;
    repeat (3) @(negedge clk);
    bus.mem_read = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset ready_req: got %b want 0", bus.ready); end
    @(negedge clk);
    bus.mem_read = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b want 1", bus.ready); end
    checks++;
    if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL reset we_n: got %b want 1", SRAM_WE_N); end
    checks++;
    if (SRAM_ADDR !== 18'h0) begin errors++; $display("FAIL reset addr: got %h want 0", SRAM_ADDR); end
    checks++;
    if (SRAM_DQ !== 16'hzzzz && SRAM_DQ !== 16'h0000) begin
      errors++; $display("FAIL reset dq: got %h want released", SRAM_DQ);
    end
    checks++;
    if (bus.data_out !== 64'h0) begin errors++; $display("FAIL reset data_out: got %h want 0", bus.data_out); end
  endtask

  task automatic test_write();
    do_access(1'b0, 1'b1, 18'h00011, 32'hDEADBEEF, 1'b0, "write");
  endtask

  task automatic test_read();
    do_access(1'b1, 1'b0, 18'h00013, 32'h0, 1'b0, "read");
    checks++;
    if (bus.data_out !== 64'h56781234DEADBEEF) begin
      errors++; $display("FAIL read_const: got %h want %h", bus.data_out, 64'h56781234DEADBEEF);
    end
  endtask

  task automatic test_write_holds();
    do_access(1'b0, 1'b1, 18'h3FFFF, 32'h0BADF00D, 1'b0, "write_top");
  endtask

  task automatic test_both();
    do_access(1'b1, 1'b1, 18'h00005, 32'hCAFE1234, 1'b0, "both");
  endtask

  task automatic test_busy_change();
    do_access(1'b0, 1'b1, 18'h00007, 32'h11223344, 1'b1, "busy_change");
    do_access(1'b1, 1'b0, 18'h00022, 32'h0, 1'b1, "busy_change_rd");
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    int          drain;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.mem_read = 1'b1; bus.address = 18'h00021; model_oe = 1'b1;
      end
      if (k == 0 || k == 8 || k == 16)
        exp_q.push_back({mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]});
      #1;
      checks++;
      if (bus.ready !== (k == 7 || k == 15)) begin
        errors++; $display("FAIL b2b ready k=%0d: got %b want %b", k, bus.ready, (k == 7 || k == 15));
      end
      if (k == 9) begin
        checks++;
        if (SRAM_ADDR !== 18'h00020) begin
          errors++; $display("FAIL b2b second_start: got %h want %h", SRAM_ADDR, 18'h00020);
        end
      end
      if (bus.ready === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.data_out !== e) begin
          errors++; $display("FAIL b2b data_out k=%0d: got %h want %h", k, bus.data_out, e);
        end
      end
    end
    bus.mem_read = 1'b0;
    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      @(negedge clk); #1;
      drain++;
      if (bus.ready === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.data_out !== e) begin
          errors++; $display("FAIL b2b drain data_out: got %h want %h", bus.data_out, e);
        end
        exp_data_out = e;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b drain: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    model_oe = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.mem_write = 1'b1; bus.address = 18'h00011; bus.data = 32'h12345678;
    @(negedge clk); #1;
    checks++;
    if (SRAM_WE_N !== 1'b0) begin errors++; $display("FAIL rst_mid we_n_t1: got %b want 0", SRAM_WE_N); end
    rst = 1'b1;
    @(negedge clk); #1;
    exp_data_out = 64'h0;
    checks++;
    if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL rst_mid we_n: got %b want 1", SRAM_WE_N); end
    checks++;
    if (SRAM_ADDR !== 18'h0) begin errors++; $display("FAIL rst_mid addr: got %h want 0", SRAM_ADDR); end
    checks++;
    if (SRAM_DQ !== 16'hzzzz && SRAM_DQ !== 16'h0000) begin
      errors++; $display("FAIL rst_mid dq: got %h want released", SRAM_DQ);
    end
    checks++;
    if (bus.data_out !== exp_data_out) begin errors++; $display("FAIL rst_mid data_out: got %h want 0", bus.data_out); end
    checks++;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_mid ready_req: got %b want 0", bus.ready); end
    @(negedge clk);
    bus.mem_write = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_mid ready_idle: got %b want 1", bus.ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_mid ready_release: got %b want 1", bus.ready); end
    @(negedge clk);
    bus.mem_read = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_mid ready_follow: got %b want 0", bus.ready); end
    #1;
    bus.mem_read = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (SRAM_WE_N !== 1'b1 || bus.ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid settle: got we_n=%b ready=%b want 1 1", SRAM_WE_N, bus.ready);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_oe = 1'b0;
    exp_data_out = 64'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(16'h4000 + i * 16'h0111);
    mem[8'h10] = 16'hBEEF;
    mem[8'h11] = 16'hDEAD;
    mem[8'h12] = 16'h1234;
    mem[8'h13] = 16'h5678;
    test_reset();
    test_write();
    test_read();
    test_write_holds();
    test_both();
    test_busy_change();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
